// File: rtl/chip8_io_responder_if.sv
`timescale 1ns/1ps
// chip8_io_responder_if
// Low-window CHIP-8 system bus as seen by the I/O responder.
//   addr     : 16-bit CPU bus address
//   cu_state : 2'b00 disabled, 2'b01 read, 2'b10 write, 2'b11 disabled
//   wdata    : CPU write data
//   rdata    : responder read data (combinational, zero wait-state)
//   hit      : responder claims the current access
// master = CPU side, slave = responder side.
interface chip8_io_responder_if;
  logic [15:0] addr;
  logic [1:0]  cu_state;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        hit;

  modport master (output addr, output cu_state, output wdata, input rdata, input hit);
  modport slave  (input addr, input cu_state, input wdata, output rdata, output hit);
endinterface

// File: rtl/chip8_io_responder.sv
`timescale 1ns/1ps
// chip8_io_responder
// Responder for the CHIP-8 low peripheral window: keyboard levels,
// blocking wait-for-key, 60 Hz delay/sound timers and a free-running RNG.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous assert, active-low
//   bus      : bus slave (addr, cu_state, wdata in; rdata, hit out)
//   keys     : raw key levels, asynchronous to clk, bit k = key k pressed
//   sound_on : sound timer is nonzero
//   tick     : one-cycle pulse in the cycle the timers decrement
// Register map:
//   0x0000 R keys[7:0]   0x0001 R keys[15:8]
//   0x0002 W arm wait    0x0002 R wait result (FF until a key completes)
//   0x0003 RW delay      0x0004 RW sound      0x000B R lfsr[7:0]
module chip8_io_responder #(
  parameter int unsigned CLK_HZ    = 1000000,
  parameter int unsigned TICK_HZ   = 60,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  chip8_io_responder_if.slave bus,
  input  logic [15:0]         keys,
  output logic                sound_on,
  output logic                tick
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [1:0] CU_READ  = 2'b01;
  localparam logic [1:0] CU_WRITE = 2'b10;

  localparam logic [15:0] A_KEY_LO = 16'h0000;
  localparam logic [15:0] A_KEY_HI = 16'h0001;
  localparam logic [15:0] A_WAIT   = 16'h0002;
  localparam logic [15:0] A_DELAY  = 16'h0003;
  localparam logic [15:0] A_SOUND  = 16'h0004;
  localparam logic [15:0] A_RNG    = 16'h000B;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_PRESS,
    W_WAIT_RELEASE,
    W_DONE
  } wait_state_t;

  logic             rd_en;
  logic             wr_en;
  logic             sel_key_lo;
  logic             sel_key_hi;
  logic             sel_wait;
  logic             sel_delay;
  logic             sel_sound;
  logic             sel_rng;
  logic             addr_mapped;
  logic [15:0]      keys_s;
  logic [CNT_W-1:0] presc_reg;
  logic [7:0]       delay_reg;
  logic [7:0]       sound_reg;
  logic [15:0]      lfsr_reg;
  logic [15:0]      lfsr_next;
  wait_state_t      wait_state_reg;
  logic [3:0]       key_idx_reg;
  logic [3:0]       low_key_idx;
  logic [7:0]       wait_result;
  logic [7:0]       rdata_mux;

  // ---------------------------------------------------------------- decode
  // 2'b11 matches neither enable, so it behaves as disabled.
  assign rd_en = (bus.cu_state == CU_READ);
  assign wr_en = (bus.cu_state == CU_WRITE);

  assign sel_key_lo  = (bus.addr == A_KEY_LO);
  assign sel_key_hi  = (bus.addr == A_KEY_HI);
  assign sel_wait    = (bus.addr == A_WAIT);
  assign sel_delay   = (bus.addr == A_DELAY);
  assign sel_sound   = (bus.addr == A_SOUND);
  assign sel_rng     = (bus.addr == A_RNG);
  assign addr_mapped = sel_key_lo | sel_key_hi | sel_wait | sel_delay | sel_sound | sel_rng;

  assign bus.hit = addr_mapped & (rd_en | wr_en);

  // ------------------------------------------------------ key synchronizer
  // Two flops per key bit; everything downstream uses keys_s only.
  for (genvar gi = 0; gi < 16; gi++) begin : g_key_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= keys[gi];
        sync_reg <= meta_reg;
      end
    end
    assign keys_s[gi] = sync_reg;
  end

  // ------------------------------------------------------------ prescaler
  assign tick = (presc_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // --------------------------------------------------------------- timers
  // A CPU write wins over the decrement when both land on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      delay_reg <= 8'h00;
      sound_reg <= 8'h00;
    end else begin
      if (wr_en && sel_delay) begin
        delay_reg <= bus.wdata;
      end else if (tick && (delay_reg != 8'h00)) begin
        delay_reg <= delay_reg - 1'b1;
      end

      if (wr_en && sel_sound) begin
        sound_reg <= bus.wdata;
      end else if (tick && (sound_reg != 8'h00)) begin
        sound_reg <= sound_reg - 1'b1;
      end
    end
  end

  assign sound_on = (sound_reg != 8'h00);

  // ----------------------------------------------------------------- LFSR
  // Galois form; the all-zero state is unreachable from a nonzero seed.
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // ------------------------------------------------------------- wait FSM
  // Lowest-numbered pressed key wins when several are down together.
  always_comb begin
    low_key_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (keys_s[i]) begin
        low_key_idx = 4'(i);
      end
    end
  end

  // Arm is honoured only from IDLE so a retried arm cannot restart a wait
  // that is already in progress; the result is consumed by reading it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_state_reg <= W_IDLE;
      key_idx_reg    <= 4'd0;
    end else begin
      unique case (wait_state_reg)
        W_IDLE: begin
          if (wr_en && sel_wait) begin
            wait_state_reg <= W_WAIT_PRESS;
          end
        end
        W_WAIT_PRESS: begin
          if (keys_s != 16'h0000) begin
            key_idx_reg    <= low_key_idx;
            wait_state_reg <= W_WAIT_RELEASE;
          end
        end
        W_WAIT_RELEASE: begin
          if (!keys_s[key_idx_reg]) begin
            wait_state_reg <= W_DONE;
          end
        end
        W_DONE: begin
          if (rd_en && sel_wait) begin
            wait_state_reg <= W_IDLE;
          end
        end
        default: wait_state_reg <= W_IDLE;
      endcase
    end
  end

  assign wait_result = (wait_state_reg == W_DONE) ? {4'h0, key_idx_reg} : 8'hFF;

  // ------------------------------------------------------------ read mux
  always_comb begin
    rdata_mux = 8'h00;
    if (rd_en) begin
      if (sel_key_lo) begin
        rdata_mux = keys_s[7:0];
      end else if (sel_key_hi) begin
        rdata_mux = keys_s[15:8];
      end else if (sel_wait) begin
        rdata_mux = wait_result;
      end else if (sel_delay) begin
        rdata_mux = delay_reg;
      end else if (sel_sound) begin
        rdata_mux = sound_reg;
      end else if (sel_rng) begin
        rdata_mux = lfsr_reg[7:0];
      end
    end
  end

  assign bus.rdata = rdata_mux;

endmodule

// File: tb/tb_chip8_io_responder.sv
`timescale 1ns/1ps
module tb_chip8_io_responder;

  localparam int CLK_HZ  = 600;
  localparam int TICK_HZ = 60;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic        sound_on;
  logic        tick;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  chip8_io_responder_if bus ();

  chip8_io_responder #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .LFSR_SEED(SEED)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .keys    (keys),
    .sound_on(sound_on),
    .tick    (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- helpers
  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit later, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_set(input logic [15:0] a, input logic [1:0] cs, input logic [7:0] d);
    bus.addr     = a;
    bus.cu_state = cs;
    bus.wdata    = d;
  endtask

  task automatic bus_idle();
    bus_set(16'h0000, 2'b00, 8'h00);
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] d, output logic h);
    bus_set(a, 2'b01, 8'h00);
    #1;
    d = bus.rdata;
    h = bus.hit;
    $display("rd addr=%04h data=%02h hit=%0b", a, d, h);
    step();
    bus_idle();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    bus_set(a, 2'b10, d);
    $display("wr addr=%04h data=%02h", a, d);
    step();
    bus_idle();
  endtask

  task automatic wait_tick(output int unsigned at, output bit ok);
    int n = 0;
    while (tick !== 1'b1 && n < 3 * DIV) begin
      step();
      n++;
    end
    ok = (tick === 1'b1);
    at = cyc;
  endtask

  function automatic logic [15:0] lfsr_model(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int lowest_bit(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    logic [7:0] d;
    logic h;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
    total++; if (sound_on !== 1'b0) begin bad++; $display("FAIL reset_sound_on got=%b exp=0", sound_on); end
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL reset_hit_idle got=%b exp=0", bus.hit); end
    reset = 1'b1;
    do_read(16'h0003, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_delay got=%02h exp=00", d); end
    do_read(16'h0004, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_sound got=%02h exp=00", d); end
    do_read(16'h0002, d, h);
    total++; if (d !== 8'hFF || h !== 1'b1) begin bad++; $display("FAIL reset_wait got=%02h/%b exp=FF/1", d, h); end
  endtask

  task automatic test_delay_timer();
    int unsigned t_prev, t_now;
    bit ok;
    logic [7:0] d;
    logic h;
    int expv;
    wait_tick(t_prev, ok);
    total++; if (!ok) begin bad++; $display("FAIL delay_align_tick got=timeout exp=tick"); end
    step();
    do_write(16'h0003, 8'd3);
    expv = 3;
    do_read(16'h0003, d, h);
    total++; if (d !== 8'(expv)) begin bad++; $display("FAIL delay_read0 got=%0d exp=%0d", d, expv); end
    for (int k = 1; k <= 4; k++) begin
      wait_tick(t_now, ok);
      total++;
      if (!ok || (t_now - t_prev) != DIV) begin
        bad++; $display("FAIL delay_tick_spacing got=%0d exp=%0d", t_now - t_prev, DIV);
      end
      t_prev = t_now;
      step();
      expv = (expv > 0) ? expv - 1 : 0;
      do_read(16'h0003, d, h);
      total++; if (d !== 8'(expv)) begin bad++; $display("FAIL delay_read%0d got=%0d exp=%0d", k, d, expv); end
      total++; if (sound_on !== 1'b0) begin bad++; $display("FAIL delay_sound_on got=%b exp=0", sound_on); end
    end
  endtask

  task automatic test_sound_same_tick();
    int unsigned t;
    bit ok;
    logic [7:0] d;
    logic h;
    int hi_cnt;
    int v;
    for (int it = 0; it < 3; it++) begin
      v = (it == 0) ? 2 : int'($urandom_range(1, 4));
      wait_tick(t, ok);
      total++; if (!ok) begin bad++; $display("FAIL sound_align_tick got=timeout exp=tick"); end
      bus_set(16'h0004, 2'b10, 8'(v));
      $display("wr addr=0004 data=%02h (tick cycle)", 8'(v));
      step();
      bus_idle();
      hi_cnt = 0;
      if (sound_on === 1'b1) hi_cnt++;
      do_read(16'h0004, d, h);
      total++; if (d !== 8'(v)) begin bad++; $display("FAIL sound_write_priority got=%0d exp=%0d", d, v); end
      while (sound_on === 1'b1 && hi_cnt < 8 * DIV) begin
        hi_cnt++;
        step();
      end
      total++; if (hi_cnt != v * DIV) begin bad++; $display("FAIL sound_on_duration got=%0d exp=%0d", hi_cnt, v * DIV); end
      do_read(16'h0004, d, h);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL sound_hold_zero got=%0d exp=0", d); end
    end
  endtask

  task automatic test_keys();
    logic [7:0] d;
    logic h;
    logic [15:0] prev, nk;
    logic [15:0] addrs [12];
    logic [11:0] exp_hit;
    prev = keys;
    for (int it = 0; it < 5; it++) begin
      nk = (it == 0) ? 16'h0210 : 16'($urandom);
      keys = nk;
      step();
      do_read(16'h0000, d, h);
      total++; if (d !== prev[7:0]) begin bad++; $display("FAIL keys_latency got=%02h exp=%02h", d, prev[7:0]); end
      do_read(16'h0001, d, h);
      total++; if (d !== nk[15:8] || h !== 1'b1) begin bad++; $display("FAIL keys_hi got=%02h/%b exp=%02h/1", d, h, nk[15:8]); end
      do_read(16'h0000, d, h);
      total++; if (d !== nk[7:0] || h !== 1'b1) begin bad++; $display("FAIL keys_lo got=%02h/%b exp=%02h/1", d, h, nk[7:0]); end
      prev = nk;
    end
    addrs = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
              16'h0007, 16'h000A, 16'h000B, 16'h000C, 16'h100B, 16'hFFFF};
    exp_hit = 12'b0001_0001_1111;
    for (int i = 0; i < 12; i++) begin
      do_read(addrs[i], d, h);
      total++; if (h !== exp_hit[i]) begin bad++; $display("FAIL hit_map addr=%04h got=%b exp=%b", addrs[i], h, exp_hit[i]); end
      if (!exp_hit[i]) begin
        total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_rdata addr=%04h got=%02h exp=00", addrs[i], d); end
      end
    end
    bus_set(16'h0000, 2'b11, 8'h00);
    #1;
    total++; if (bus.hit !== 1'b0 || bus.rdata !== 8'h00) begin bad++; $display("FAIL cu_state3 got=%02h/%b exp=00/0", bus.rdata, bus.hit); end
    bus_set(16'h0000, 2'b10, 8'hA5);
    #1;
    total++; if (bus.hit !== 1'b1 || bus.rdata !== 8'h00) begin bad++; $display("FAIL write_rdata got=%02h/%b exp=00/1", bus.rdata, bus.hit); end
    step();
    bus_idle();
    do_read(16'h0000, d, h);
    total++; if (d !== prev[7:0]) begin bad++; $display("FAIL keys_write_ignored got=%02h exp=%02h", d, prev[7:0]); end
    keys = 16'h0000;
    repeat (3) step();
  endtask

  task automatic test_wait_fsm();
    logic [7:0] d;
    logic h;
    logic [15:0] mask;
    int lo;
    bit pre_held;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        mask = 16'h0220;
        pre_held = 1'b0;
      end else begin
        mask = 16'h0000;
        repeat (int'($urandom_range(1, 3))) mask |= 16'(1) << $urandom_range(0, 15);
        pre_held = (it % 2) == 0;
      end
      lo = lowest_bit(mask);
      keys = 16'h0000;
      repeat (3) step();
      if (pre_held) begin
        keys = mask;
        repeat (3) step();
      end
      do_write(16'h0002, 8'($urandom));
      do_read(16'h0002, d, h);
      total++; if (d !== 8'hFF) begin bad++; $display("FAIL wait_armed got=%02h exp=FF", d); end
      if (!pre_held) begin
        keys = mask;
        repeat (3) step();
      end
      do_write(16'h0002, 8'($urandom));
      do_read(16'h0002, d, h);
      total++; if (d !== 8'hFF) begin bad++; $display("FAIL wait_pressed got=%02h exp=FF", d); end
      if (it % 3 != 2) begin
        // other keys released first must not complete the wait
        keys = mask & (16'(1) << lo);
        repeat (3) step();
        do_read(16'h0002, d, h);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL wait_other_release got=%02h exp=FF", d); end
      end
      keys = mask & ~(16'(1) << lo);
      repeat (3) step();
      if (it != 0) begin
        do_write(16'h0002, 8'($urandom));
      end
      do_read(16'h0002, d, h);
      total++; if (d !== {4'h0, 4'(lo)}) begin bad++; $display("FAIL wait_result got=%02h exp=%02h", d, {4'h0, 4'(lo)}); end
      do_read(16'h0002, d, h);
      total++; if (d !== 8'hFF) begin bad++; $display("FAIL wait_cleared got=%02h exp=FF", d); end
    end
    keys = 16'h0000;
    repeat (3) step();
  endtask

  task automatic test_lfsr();
    logic [15:0] model;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    bus_set(16'h000B, 2'b01, 8'h00);
    #1;
    model = SEED;
    total++; if (bus.rdata !== model[7:0]) begin bad++; $display("FAIL lfsr_seed got=%02h exp=%02h", bus.rdata, model[7:0]); end
    for (int n = 1; n <= 70000; n++) begin
      @(posedge clk);
      #1;
      model = lfsr_model(model);
      total++;
      if (bus.rdata !== model[7:0] || bus.hit !== 1'b1) begin
        bad++;
        $display("FAIL lfsr_cycle%0d got=%02h exp=%02h", n, bus.rdata, model[7:0]);
        break;
      end
    end
    bus_idle();
    step();
  endtask

  task automatic test_reset_midwait();
    logic [7:0] d;
    logic h;
    do_write(16'h0003, 8'($urandom_range(20, 200)));
    do_write(16'h0004, 8'($urandom_range(20, 200)));
    do_write(16'h0002, 8'h00);
    keys = 16'(1) << $urandom_range(0, 15);
    repeat (4) step();
    do_read(16'h0002, d, h);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL midwait_pending got=%02h exp=FF", d); end
    total++; if (sound_on !== 1'b1) begin bad++; $display("FAIL midwait_sound_on got=%b exp=1", sound_on); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (sound_on !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL async_clear_outputs got=%b/%b exp=0/0", sound_on, tick); end
    bus_set(16'h0003, 2'b01, 8'h00);
    #1;
    total++; if (bus.rdata !== 8'h00) begin bad++; $display("FAIL async_clear_delay got=%02h exp=00", bus.rdata); end
    bus_set(16'h0000, 2'b01, 8'h00);
    #1;
    total++; if (bus.rdata !== 8'h00 && keys[7:0] != 8'h00) begin bad++; $display("FAIL async_clear_sync got=%02h exp=00", bus.rdata); end
    bus_set(16'h0001, 2'b01, 8'h00);
    #1;
    total++; if (bus.rdata !== 8'h00 && keys[15:8] != 8'h00) begin bad++; $display("FAIL async_clear_sync_hi got=%02h exp=00", bus.rdata); end
    bus_idle();
    step();
    reset = 1'b1;
    do_read(16'h0002, d, h);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL after_reset_wait got=%02h exp=FF", d); end
    do_read(16'h0003, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL after_reset_delay got=%02h exp=00", d); end
    do_read(16'h0004, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL after_reset_sound got=%02h exp=00", d); end
    keys = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_delay_timer();
    test_sound_same_tick();
    test_keys();
    test_wait_fsm();
    test_lfsr();
    test_reset_midwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip8_io_responder.md
Name: chip8_io_responder

Overview:
- Bus responder for the low peripheral window of the CHIP-8 system bus (addr, cu_state, data), serving the CPU's keyboard, wait-for-key, delay timer, sound timer and RNG accesses.
- Holds 60 Hz delay and sound timers, a key wait-press-release FSM, and a free-running LFSR.
- Sits beside the PPU register block; the top level muxes its rdata onto CPU data_in when hit=1.

Parameters:
- CLK_HZ, 1000000, system clock frequency.
- TICK_HZ, 60, timer decrement rate; DIV = CLK_HZ/TICK_HZ, integer, >=2.
- LFSR_SEED, 16'hACE1, RNG reset value; must be nonzero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- addr  in  16  bus address from the CPU.
- cu_state  in  2  2'b00 DISABLED, 2'b01 READ_ENABLE, 2'b10 WRITE_ENABLE; 2'b11 treated as DISABLED.
- wdata  in  8  CPU write data.
- rdata  out  8  read data, combinational from addr/cu_state and registered state.
- hit  out  1  addr is in {0x0000..0x0004, 0x000B} and cu_state != DISABLED.
- keys  in  16  raw key levels, bit k = key k pressed, asynchronous to clk.
- sound_on  out  1  sound_timer != 0.
- tick  out  1  one-cycle pulse at each timer decrement point.

Behaviour:
- Register map:
  - 0x0000 R: keys_s[7:0]. 0x0001 R: keys_s[15:8]. Writes to both are ignored.
  - 0x0002 W: arm the wait FSM. 0x0002 R: result byte.
  - 0x0003 R/W: delay_timer. 0x0004 R/W: sound_timer.
  - 0x000B R: lfsr[7:0]. Writes ignored.
  - Unmapped addresses: rdata=0, hit=0, writes ignored.
- Read timing: zero wait-state. rdata is valid in the same cycle addr and cu_state are presented, because the CPU samples on the next edge. rdata=0 when cu_state != READ_ENABLE.
- Write timing: wdata is captured on the rising edge where cu_state==WRITE_ENABLE.
- keys synchronizer: 2-FF synchronizer gives keys_s; all logic uses keys_s only. Latency from keys to keys_s is 2 cycles.
- Prescaler: counter runs 0..DIV-1 and wraps. tick=1 in the cycle the count equals DIV-1.
- Timers, on tick:
  - Each timer decrements if nonzero and holds at 0 (no wrap).
  - A write to a timer in the same cycle as tick takes priority; no decrement that cycle.
  - sound_on is registered-state derived and has no extra latency.
- LFSR: 16-bit Galois, advances every cycle, independent of bus activity.
  - Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Never reaches 0 from a nonzero seed.
- Wait FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE; 4-bit key_idx register.
  - IDLE: write to 0x0002 (any data) -> WAIT_PRESS. Writes in any other state are ignored, so the CPU's re-issued arm on retry does not lose progress.
  - WAIT_PRESS: if keys_s != 0, latch key_idx = lowest set bit index -> WAIT_RELEASE.
  - WAIT_RELEASE: when keys_s[key_idx]==0 -> DONE. Other keys are ignored.
  - DONE: a read of 0x0002 returns {4'h0,key_idx} and moves to IDLE on that edge (read-to-clear).
  - Read of 0x0002 in any state other than DONE returns 8'hFF with no state change.
  - A key already held at arm time counts as a press (the next WAIT_PRESS cycle latches it).
- Reset (asynchronous assert, synchronous release):
  - delay_timer=0, sound_timer=0, prescaler=0, lfsr=LFSR_SEED.
  - FSM=IDLE, key_idx=0, sync flops=0.
  - Outputs: tick=0, sound_on=0. rdata=0 and hit=0 follow from the bus inputs.
  - Reset mid-wait discards the pending key.

Test Plan:
- CLK_HZ=600, TICK_HZ=60 (DIV=10). Write 0x03 <- 3; read 0x03 each tick. Required: reads 3,2,1,0,0, decrements exactly 10 cycles apart, sound_on stays 0.
- Write 0x04 <- 2 in the same cycle as tick. Required: value is 2 after that edge; sound_on=1 for exactly 20 cycles, then 0.
- keys=16'h0210, wait 2 cycles. Required: read 0x00 -> 8'h10, read 0x01 -> 8'h02, hit=1. Read 0x0007 -> rdata=0, hit=0.
- Arm 0x02, read 0x02 -> FF. Press keys bits 5 and 9, re-arm (ignored), read -> FF. Release bit 9 -> still FF. Release bit 5 -> next read returns 8'h05. Following read -> FF (IDLE).
- After reset, read 0x0B on cycles 1 and 2. Required: values match a Galois LFSR model from 16'hACE1 with mask B400; the value is never 0 over 70000 cycles.
- Drop reset low during WAIT_RELEASE with timers nonzero. Required: all state clears asynchronously; after release, read 0x02 -> FF and 0x03/0x04 -> 0.
